// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned MULU (low word) / DIVU sequencer that borrows the shared EX-stage ALU.
// Optional macro MULDIV_EARLY_OUT_EN: MULU finishes as soon as the remaining multiplier bits are zero.
module alu_muldiv_seq #(
  parameter int unsigned ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result_lo,
  output logic [31:0] result_hi,
  output logic        div_by_zero,
  output logic        alu_sel,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_s
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = $clog2(ITER);

  localparam logic [3:0] OP_NONE = 4'b0000;
  localparam logic [3:0] OP_ADDU = 4'b0001;
  localparam logic [3:0] OP_SUBU = 4'b0011;
  localparam logic [3:0] OP_SLTU = 4'b0101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DCMP,
    S_DSUB,
    S_DONE
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  acc_q;
  logic [W-1:0]  mcand_q;
  logic [W-1:0]  mplier_q;
  logic [W-1:0]  rem_q;
  logic [W-1:0]  quo_q;
  logic [W-1:0]  dvsr_q;
  logic          ge_q;
  logic [W-1:0]  res_lo_q;
  logic [W-1:0]  res_hi_q;
  logic          dbz_q;

  logic [W:0]    r_d;
  logic [W-1:0]  acc_d;
  logic [W-1:0]  mplier_d;
  logic          last_d;
  logic          mul_end_d;

  // Shifted partial remainder; bit W is the carry-out that the 32-bit compare cannot see.
  assign r_d      = {rem_q, quo_q[W-1]};
  assign acc_d    = mplier_q[0] ? alu_s : acc_q;
  assign mplier_d = mplier_q >> 1;
  assign last_d   = (cnt_q == CW'(ITER - 1));

`ifdef MULDIV_EARLY_OUT_EN
  assign mul_end_d = last_d || (mplier_d == '0);
`else
  assign mul_end_d = last_d;
`endif

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign alu_sel     = (state_q == S_MUL) || (state_q == S_DCMP) || (state_q == S_DSUB);
  assign result_lo   = res_lo_q;
  assign result_hi   = res_hi_q;
  assign div_by_zero = dbz_q;

  // ALU request decode
  always_comb begin
    alu_op = OP_NONE;
    alu_a  = '0;
    alu_b  = '0;
    case (state_q)
      S_MUL: begin
        alu_op = OP_ADDU;
        alu_a  = acc_q;
        alu_b  = mcand_q;
      end
      S_DCMP: begin
        alu_op = OP_SLTU;
        alu_a  = r_d[W-1:0];
        alu_b  = dvsr_q;
      end
      S_DSUB: begin
        alu_op = OP_SUBU;
        alu_a  = rem_q;
        alu_b  = dvsr_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      ge_q     <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            dbz_q <= 1'b0;
            cnt_q <= '0;
            if (!div) begin
              acc_q    <= '0;
              mcand_q  <= a;
              mplier_q <= b;
`ifdef MULDIV_EARLY_OUT_EN
              if (b == '0) begin
                res_lo_q <= '0;
                res_hi_q <= '0;
                state_q  <= S_DONE;
              end else begin
                state_q  <= S_MUL;
              end
`else
              state_q  <= S_MUL;
`endif
            end else if (b == '0) begin
              res_lo_q <= '1;
              res_hi_q <= a;
              dbz_q    <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              rem_q   <= '0;
              quo_q   <= a;
              dvsr_q  <= b;
              state_q <= S_DCMP;
            end
          end
        end
        S_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_q + CW'(1);
          if (mul_end_d) begin
            res_lo_q <= acc_d;
            res_hi_q <= '0;
            state_q  <= S_DONE;
          end
        end
        S_DCMP: begin
          rem_q   <= r_d[W-1:0];
          quo_q   <= {quo_q[W-2:0], 1'b0};
          ge_q    <= r_d[W] | ~alu_s[0];
          state_q <= S_DSUB;
        end
        S_DSUB: begin
          if (ge_q) begin
            rem_q    <= alu_s;
            quo_q[0] <= 1'b1;
          end
          cnt_q <= cnt_q + CW'(1);
          if (last_d) begin
            res_lo_q <= ge_q ? {quo_q[W-1:1], 1'b1} : quo_q;
            res_hi_q <= ge_q ? alu_s : rem_q;
            state_q  <= S_DONE;
          end else begin
            state_q  <= S_DCMP;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
